// File: rtl/regfile_scan_ctrl_pkg.sv
// Shared definitions for the register-file scan controller: default sizes,
// FSM state encoding and a helper for address widths.
package regfile_scan_ctrl_pkg;

    // Native register width of the register file this block scans.
    localparam int WORD_LENGTH  = 32;
    // Default number of registers in the scan chain.
    localparam int DEFAULT_SIZE = 16;

    // Scan controller states. The NEXT decision is not a state of its own:
    // it is taken combinationally at the end of SHIFT (mode 0) or WRITE.
    typedef enum logic [2:0] {
        SCAN_IDLE  = 3'd0,
        SCAN_LOAD  = 3'd1,
        SCAN_SHIFT = 3'd2,
        SCAN_WRITE = 3'd3,
        SCAN_DONE  = 3'd4
    } scan_state_e;

    // Address width for n entries; never returns 0 so a one-entry
    // register file still gets a legal one-bit port.
    function automatic int addr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_scan_ctrl_shift_reg.sv
// Parallel-load, serial-in/serial-out shift register. Bits leave at bit 0
// (LSB first) and new serial data enters at the top bit.
module scan_shift_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] parIn,
    input  logic             sIn,
    output logic             sOut,
    output logic [WIDTH-1:0] parOut
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] shifted;

    // Right-shift network: each bit takes its upper neighbour, the top bit
    // takes the serial input.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_top
                assign shifted[gi] = sIn;
            end else begin : g_mid
                assign shifted[gi] = data_q[gi + 1];
            end
        end
    endgenerate

    // Parallel load wins over shift; otherwise the contents hold.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = parIn;
        end else if (shift) begin
            data_d = shifted;
        end
    end

    // Storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign sOut   = data_q[0];
    assign parOut = data_q;

endmodule

// File: rtl/regfile_scan_ctrl.sv
// Register-file scan controller: walks every register address, dumps each
// word serially (LSB first) and, in mode 1, writes back the word shifted in.
module regfile_scan_ctrl
    import regfile_scan_ctrl_pkg::*;
#(
    parameter int  SIZE  = DEFAULT_SIZE,
    parameter int  WIDTH = WORD_LENGTH,
    localparam int AW    = addr_bits(SIZE),
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic             sEnable,
    input  logic             sIn,
    output logic             sOut,
    output logic             sValid,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    rfReadAddr,
    input  logic [WIDTH-1:0] rfReadData,
    output logic             rfWriteEnable,
    output logic [AW-1:0]    rfWriteAddr,
    output logic [WIDTH-1:0] rfWriteData
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(SIZE - 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);

    scan_state_e      state_q, state_d;
    logic [AW-1:0]    addr_q,  addr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             mode_q,  mode_d;
    logic             done_q,  done_d;

    logic             sr_load;
    logic             sr_shift;
    logic             sr_sout;
    logic [WIDTH-1:0] sr_par;
    logic             word_end;

    scan_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk    (clk),
        .rst    (rst),
        .load   (sr_load),
        .shift  (sr_shift),
        .parIn  (rfReadData),
        .sIn    (sIn),
        .sOut   (sr_sout),
        .parOut (sr_par)
    );

    // A word is finished after its last enabled bit (dump only) or after
    // its write-back cycle; the next address or DONE is chosen then.
    assign word_end = ((state_q == SCAN_SHIFT) && sEnable && (count_q == LAST_BIT) && !mode_q)
                    || (state_q == SCAN_WRITE);

    // Next-state, counters and shift-register controls.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;

        case (state_q)
            SCAN_IDLE: begin
                if (start && !abort) begin
                    state_d = SCAN_LOAD;
                    addr_d  = '0;
                    mode_d  = mode;
                end
            end
            SCAN_LOAD: begin
                sr_load = 1'b1;
                count_d = '0;
                state_d = SCAN_SHIFT;
            end
            SCAN_SHIFT: begin
                if (sEnable) begin
                    sr_shift = 1'b1;
                    count_d  = count_q + CW'(1);
                    if ((count_q == LAST_BIT) && mode_q) begin
                        state_d = SCAN_WRITE;
                    end
                end
            end
            SCAN_WRITE: begin
                state_d = state_q;
            end
            SCAN_DONE: begin
                state_d = SCAN_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = SCAN_IDLE;
            end
        endcase

        if (word_end) begin
            if (addr_q == LAST_ADDR) begin
                state_d = SCAN_DONE;
            end else begin
                addr_d  = addr_q + AW'(1);
                state_d = SCAN_LOAD;
            end
        end

        // Abort abandons any scan; a pending done pulse is dropped as well.
        if (abort && (state_q != SCAN_IDLE)) begin
            state_d = SCAN_IDLE;
            done_d  = 1'b0;
        end
    end

    // Controller state registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // sOut follows the shift register's LSB throughout SHIFT so it stays
    // frozen while sEnable stalls the shift; it is forced low elsewhere.
    assign busy          = (state_q != SCAN_IDLE);
    assign done          = done_q;
    assign sValid        = (state_q == SCAN_SHIFT) && sEnable;
    assign sOut          = (state_q == SCAN_SHIFT) && sr_sout;
    assign rfReadAddr    = addr_q;
    assign rfWriteEnable = (state_q == SCAN_WRITE) && !abort && !rst;
    assign rfWriteAddr   = addr_q;
    assign rfWriteData   = sr_par;

endmodule
